// File: rtl/axi_fault_monitor_if.sv
// AXI4 AW/B/AR/R signal bundle observed by axi_fault_monitor.
// The monitor modport is fully passive: every signal is an input.
interface axi_fault_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic              rvalid;
  logic              rready;
  logic              rlast;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;

  modport master (
    output awvalid, awaddr, awid, bready, arvalid, araddr, arid, arlen, rready,
    input  awready, bvalid, bresp, bid, arready, rvalid, rlast, rresp, rid
  );

  modport slave (
    input  awvalid, awaddr, awid, bready, arvalid, araddr, arid, arlen, rready,
    output awready, bvalid, bresp, bid, arready, rvalid, rlast, rresp, rid
  );

  modport monitor (
    input awvalid, awready, awaddr, awid, bvalid, bready, bresp, bid,
          arvalid, arready, araddr, arid, arlen,
          rvalid, rready, rlast, rresp, rid
  );
endinterface

// File: rtl/axi_fault_monitor.sv
// Passive AXI4 fault monitor: attributes SLVERR/DECERR responses to the
// originating transaction, keeps sticky records, counters and protocol flags.
module axi_fault_monitor #(
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 4,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8,
  parameter bit FATAL_EN = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  axi_fault_monitor_if.monitor bus,
  input  logic              i_clr,
  input  logic              i_cnt_clr,
  output logic              access_fault,
  output logic              fault_pulse,
  output logic              fault_is_wr,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [ID_W-1:0]   fault_id,
  output logic [1:0]        fault_resp,
  output logic [7:0]        fault_beat,
  output logic [CNT_W-1:0]  wr_fault_cnt,
  output logic [CNT_W-1:0]  rd_fault_cnt,
  output logic              proto_err,
  output logic [2:0]        proto_code
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic aw_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = bus.awvalid & bus.awready;
  assign b_hs  = bus.bvalid  & bus.bready;
  assign ar_hs = bus.arvalid & bus.arready;
  assign r_hs  = bus.rvalid  & bus.rready;

  logic [ADDR_W-1:0] wq_addr [DEPTH];
  logic [ID_W-1:0]   wq_id   [DEPTH];
  logic [ADDR_W-1:0] rq_addr [DEPTH];
  logic [ID_W-1:0]   rq_id   [DEPTH];
  logic [7:0]        rq_len  [DEPTH];
  logic [PTR_W-1:0]  wq_wp, wq_rp, rq_wp, rq_rp;
  logic [PTR_W:0]    wq_cnt, rq_cnt;
  logic [7:0]        beat_cnt;

  logic wq_empty, wq_full, wq_pop, wq_push, wq_ovf;
  logic rq_empty, rq_full, rq_pop, rq_push, rq_ovf;
  assign wq_empty = (wq_cnt == '0);
  assign wq_full  = (wq_cnt == FULL_CNT);
  assign wq_pop   = b_hs & ~wq_empty;
  assign wq_push  = aw_hs & (~wq_full | wq_pop);
  assign wq_ovf   = aw_hs & wq_full & ~wq_pop;
  assign rq_empty = (rq_cnt == '0);
  assign rq_full  = (rq_cnt == FULL_CNT);
  assign rq_pop   = r_hs & bus.rlast & ~rq_empty;
  assign rq_push  = ar_hs & (~rq_full | rq_pop);
  assign rq_ovf   = ar_hs & rq_full & ~rq_pop;

  // Queue storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge i_clk) begin
    if (wq_push) begin
      wq_addr[wq_wp] <= bus.awaddr;
      wq_id[wq_wp]   <= bus.awid;
    end
    if (rq_push) begin
      rq_addr[rq_wp] <= bus.araddr;
      rq_id[rq_wp]   <= bus.arid;
      rq_len[rq_wp]  <= bus.arlen;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wq_wp    <= '0;
      wq_rp    <= '0;
      wq_cnt   <= '0;
      rq_wp    <= '0;
      rq_rp    <= '0;
      rq_cnt   <= '0;
      beat_cnt <= '0;
    end else begin
      if (wq_push) wq_wp <= wq_wp + 1'b1;
      if (wq_pop)  wq_rp <= wq_rp + 1'b1;
      if (wq_push && !wq_pop)      wq_cnt <= wq_cnt + 1'b1;
      else if (!wq_push && wq_pop) wq_cnt <= wq_cnt - 1'b1;
      if (rq_push) rq_wp <= rq_wp + 1'b1;
      if (rq_pop)  rq_rp <= rq_rp + 1'b1;
      if (rq_push && !rq_pop)      rq_cnt <= rq_cnt + 1'b1;
      else if (!rq_push && rq_pop) rq_cnt <= rq_cnt - 1'b1;
      if (r_hs) beat_cnt <= bus.rlast ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  logic              b_fault, r_fault;
  logic [ADDR_W-1:0] b_addr, r_addr;
  logic [ID_W-1:0]   b_id, r_id;
  logic              b_mismatch, r_mismatch;
  logic [2:0]        proto_new;
  assign b_fault    = b_hs & (bus.bresp != 2'b00);
  assign r_fault    = r_hs & (bus.rresp != 2'b00);
  assign b_addr     = wq_empty ? '0 : wq_addr[wq_rp];
  assign b_id       = wq_empty ? bus.bid : wq_id[wq_rp];
  assign r_addr     = rq_empty ? '0 : rq_addr[rq_rp];
  assign r_id       = rq_empty ? bus.rid : rq_id[rq_rp];
  assign b_mismatch = b_hs & ~wq_empty & (bus.bid != wq_id[wq_rp]);
  assign r_mismatch = r_hs & ~rq_empty & (bus.rid != rq_id[rq_rp]);

  // Several errors in one cycle: the lowest code is recorded.
  always_comb begin
    proto_new = 3'd0;
    if (b_hs && wq_empty)      proto_new = 3'd1;
    else if (r_hs && rq_empty) proto_new = 3'd2;
    else if (b_mismatch)       proto_new = 3'd3;
    else if (r_mismatch)       proto_new = 3'd4;
    else if (wq_ovf)           proto_new = 3'd5;
    else if (rq_ovf)           proto_new = 3'd6;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      access_fault <= 1'b0;
      fault_pulse  <= 1'b0;
      fault_is_wr  <= 1'b0;
      fault_addr   <= '0;
      fault_id     <= '0;
      fault_resp   <= '0;
      fault_beat   <= '0;
      wr_fault_cnt <= '0;
      rd_fault_cnt <= '0;
      proto_err    <= 1'b0;
      proto_code   <= '0;
    end else begin
      fault_pulse <= b_fault | r_fault;
      // i_clr re-arms the record, so a fault in the same cycle is captured.
      if ((b_fault || r_fault) && (!access_fault || i_clr)) begin
        access_fault <= 1'b1;
        fault_is_wr  <= b_fault;
        fault_addr   <= b_fault ? b_addr : r_addr;
        fault_id     <= b_fault ? b_id : r_id;
        fault_resp   <= b_fault ? bus.bresp : bus.rresp;
        fault_beat   <= b_fault ? 8'd0 : beat_cnt;
      end else if (i_clr) begin
        access_fault <= 1'b0;
        fault_is_wr  <= 1'b0;
        fault_addr   <= '0;
        fault_id     <= '0;
        fault_resp   <= '0;
        fault_beat   <= '0;
      end
      if (proto_new != 3'd0 && (!proto_err || i_clr)) begin
        proto_err  <= 1'b1;
        proto_code <= proto_new;
      end else if (i_clr) begin
        proto_err  <= 1'b0;
        proto_code <= '0;
      end
      if (i_cnt_clr)                       wr_fault_cnt <= b_fault ? CNT_W'(1) : '0;
      else if (b_fault && ~&wr_fault_cnt) wr_fault_cnt <= wr_fault_cnt + CNT_W'(1);
      if (i_cnt_clr)                       rd_fault_cnt <= r_fault ? CNT_W'(1) : '0;
      else if (r_fault && ~&rd_fault_cnt) rd_fault_cnt <= rd_fault_cnt + CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (FATAL_EN && i_rst_n) begin
      if (b_fault) $fatal(1, "axi_fault_monitor: B fault resp=%0d addr=0x%0h", bus.bresp, b_addr);
      if (r_fault) $fatal(1, "axi_fault_monitor: R fault resp=%0d addr=0x%0h", bus.rresp, r_addr);
    end
  end
`endif
endmodule
